// File: rtl/hdmi_link_pkg.sv
// Shared types for the HDMI link bring-up sequencer: state encodings and counter sizing.
package hdmi_link_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_ON  = 3'd1,
        CONFIG  = 3'd2,
        BACKOFF = 3'd3,
        WAIT_TX = 3'd4,
        SETTLE  = 3'd5,
        RUN     = 3'd6,
        FAULT   = 3'd7
    } link_state_e;

    // Width of the shared cycle counter: enough to hold the largest terminal value.
    function automatic int unsigned count_width(input int unsigned debounce,
                                                input int unsigned backoff,
                                                input int unsigned settle);
        int unsigned m;
        int unsigned w;
        m = debounce;
        if (backoff > m) m = backoff;
        if (settle > m)  m = settle;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_link_sequencer.sv
// Per-port HDMI bring-up: debounce hot-plug, run retimer config with retries,
// wait for the TX path and settle, then enable the stream; handles unplug/TX loss anywhere.
module hdmi_link_sequencer
    import hdmi_link_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned BACKOFF_CYCLES  = 20_000_000,
    parameter int unsigned SETTLE_CYCLES   = 200_000,
    parameter int unsigned RETRY_LIMIT     = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       hpd,
    input  logic       tx_ready,
    output logic       cfg_request,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       run,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned CW = count_width(DEBOUNCE_CYCLES, BACKOFF_CYCLES, SETTLE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(RETRY_LIMIT);

    logic          hpd_s;
    link_state_e   state_q;
    logic [CW-1:0] count;
    logic [3:0]    retry_count;
    logic [3:0]    retry_next;
    logic          unplug_pending;

    bit_synchronizer #(.RESET_VALUE(1'b0)) u_hpd_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (hpd),
        .q       (hpd_s)
    );

    assign retry_next = retry_count + 4'd1;
    assign state      = state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            count          <= '0;
            retry_count    <= '0;
            unplug_pending <= 1'b0;
            cfg_request    <= 1'b0;
            run            <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hpd_s) begin
                        state_q <= DEB_ON;
                        count   <= '0;
                    end
                end

                DEB_ON: begin
                    if (!hpd_s) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                    end else if (count == DEB_LAST) begin
                        state_q        <= CONFIG;
                        count          <= '0;
                        cfg_request    <= 1'b1;
                        unplug_pending <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                // Never abandon a transaction; an unplug is only acted on at the response.
                CONFIG: begin
                    if (!hpd_s) unplug_pending <= 1'b1;
                    if (cfg_done || cfg_error) begin
                        cfg_request <= 1'b0;
                        count       <= '0;
                        if (unplug_pending || !hpd_s) begin
                            state_q        <= IDLE;
                            retry_count    <= '0;
                            unplug_pending <= 1'b0;
                        end else if (cfg_error) begin
                            retry_count <= retry_next;
                            if (retry_next == RETRY_MAX) begin
                                state_q <= FAULT;
                                fault   <= 1'b1;
                            end else begin
                                state_q <= BACKOFF;
                            end
                        end else begin
                            retry_count <= '0;
                            state_q     <= WAIT_TX;
                        end
                    end
                end

                BACKOFF: begin
                    if (!hpd_s) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                    end else if (count == BACKOFF_LAST) begin
                        state_q        <= CONFIG;
                        count          <= '0;
                        cfg_request    <= 1'b1;
                        unplug_pending <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                WAIT_TX: begin
                    if (!hpd_s) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                    end else if (tx_ready) begin
                        state_q <= SETTLE;
                        count   <= '0;
                    end
                end

                SETTLE: begin
                    if (!hpd_s) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                    end else if (!tx_ready) begin
                        state_q <= WAIT_TX;
                        count   <= '0;
                    end else if (count == SETTLE_LAST) begin
                        state_q <= RUN;
                        count   <= '0;
                        run     <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                // TX loss wins over unplug; unplug needs a full debounce of low hpd.
                RUN: begin
                    if (!tx_ready) begin
                        state_q <= WAIT_TX;
                        count   <= '0;
                        run     <= 1'b0;
                    end else if (hpd_s) begin
                        count <= '0;
                    end else if (count == DEB_LAST) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                        run         <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                FAULT: begin
                    cfg_request <= 1'b0;
                    if (!hpd_s) begin
                        state_q     <= IDLE;
                        count       <= '0;
                        retry_count <= '0;
                        fault       <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    count   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed self-checking bench for hdmi_link_sequencer with short timing parameters.
module tb_hdmi_link_sequencer;

    logic       clock;
    logic       reset_n;
    logic       hpd;
    logic       tx_ready;
    logic       cfg_request;
    logic       cfg_done;
    logic       cfg_error;
    logic       run;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONFIG  = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    hdmi_link_sequencer #(
        .DEBOUNCE_CYCLES (8),
        .BACKOFF_CYCLES  (16),
        .SETTLE_CYCLES   (4),
        .RETRY_LIMIT     (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hpd         (hpd),
        .tx_ready    (tx_ready),
        .cfg_request (cfg_request),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error),
        .run         (run),
        .fault       (fault),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int max_cyc, input string tag);
        int n = 0;
        while (state !== tgt && n < max_cyc) begin
            step(1);
            n++;
        end
        chk(tag, 32'(state), 32'(tgt));
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (cfg_request !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, 32'(cfg_request), 32'd1);
    endtask

    task automatic pulse_done();
        cfg_done = 1'b1;
        step(1);
        cfg_done = 1'b0;
    endtask

    task automatic pulse_error();
        cfg_error = 1'b1;
        step(1);
        cfg_error = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;

        reset_n   = 1'b0;
        hpd       = 1'b0;
        tx_ready  = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        step(3);
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_outputs", {29'd0, run, cfg_request, fault}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Happy path: capture edge of hpd plus 2 sync + 8 debounce edges to cfg_request
        tx_ready = 1'b1;
        hpd      = 1'b1;
        n = 0;
        while (cfg_request !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        chk("hpd_to_cfg_request_edges", 32'(n), 32'd11);
        chk("config_state", 32'(state), 32'(S_CONFIG));
        step(4);
        chk("cfg_request_held", 32'(cfg_request), 32'd1);
        pulse_done();
        chk("done_to_wait_tx", 32'(state), 32'(S_WAIT_TX));
        chk("cfg_request_drop", 32'(cfg_request), 32'd0);
        step(1);
        chk("settle_entry", 32'(state), 32'(S_SETTLE));
        step(3);
        chk("run_low_in_settle", 32'(run), 32'd0);
        step(1);
        chk("run_after_settle", 32'(run), 32'd1);
        chk("run_state", 32'(state), 32'(S_RUN));
        chk("no_fault_in_run", 32'(fault), 32'd0);

        // RUN: short unplug glitch is filtered
        hpd  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (run !== 1'b1) seen = 1'b1;
        end
        hpd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (run !== 1'b1) seen = 1'b1;
        end
        chk("short_unplug_run_drop", 32'(seen), 32'd0);
        chk("short_unplug_state", 32'(state), 32'(S_RUN));

        // RUN: TX loss and recovery without reconfiguration
        tx_ready = 1'b0;
        step(1);
        chk("txloss_run", 32'(run), 32'd0);
        chk("txloss_state", 32'(state), 32'(S_WAIT_TX));
        tx_ready = 1'b1;
        seen = 1'b0;
        step(1);
        chk("txback_settle", 32'(state), 32'(S_SETTLE));
        for (int i = 0; i < 4; i++) begin
            if (cfg_request !== 1'b0) seen = 1'b1;
            step(1);
        end
        chk("txback_run", 32'(run), 32'd1);
        chk("txback_no_request", 32'(seen), 32'd0);

        // RUN: long unplug exits to IDLE after 8 low samples
        hpd = 1'b0;
        step(9);
        chk("long_unplug_run_hold", 32'(run), 32'd1);
        step(1);
        chk("long_unplug_run", 32'(run), 32'd0);
        chk("long_unplug_state", 32'(state), 32'(S_IDLE));
        step(3);

        // Plug glitch never reaches CONFIG
        hpd  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (cfg_request !== 1'b0) seen = 1'b1;
        end
        hpd = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (cfg_request !== 1'b0) seen = 1'b1;
        end
        chk("glitch_no_request", 32'(seen), 32'd0);
        chk("glitch_state", 32'(state), 32'(S_IDLE));

        // Retry twice with 16-cycle backoff, then fault
        hpd = 1'b1;
        wait_req("retry_first_request");
        for (int r = 0; r < 2; r++) begin
            pulse_error();
            chk("error_to_backoff", 32'(state), 32'(S_BACKOFF));
            chk("backoff_no_request", 32'(cfg_request), 32'd0);
            n = 0;
            while (state === S_BACKOFF && n < 100) begin
                step(1);
                n++;
            end
            chk("backoff_length", 32'(n), 32'd16);
            chk("backoff_to_config", 32'(state), 32'(S_CONFIG));
            chk("backoff_rerequest", 32'(cfg_request), 32'd1);
        end
        pulse_error();
        chk("fault_state", 32'(state), 32'(S_FAULT));
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_no_request", 32'(cfg_request), 32'd0);
        hpd = 1'b0;
        step(3);
        chk("fault_exit_state", 32'(state), 32'(S_IDLE));
        chk("fault_exit_flag", 32'(fault), 32'd0);
        step(2);

        // Unplug during CONFIG: transaction completes, then IDLE
        hpd = 1'b1;
        wait_req("unplug_cfg_request");
        hpd = 1'b0;
        step(5);
        chk("unplug_cfg_held", 32'(cfg_request), 32'd1);
        chk("unplug_cfg_state", 32'(state), 32'(S_CONFIG));
        pulse_done();
        chk("unplug_cfg_idle", 32'(state), 32'(S_IDLE));
        chk("unplug_cfg_drop", 32'(cfg_request), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (run !== 1'b0) seen = 1'b1;
        end
        chk("unplug_cfg_no_run", 32'(seen), 32'd0);

        // Async reset while in RUN
        hpd = 1'b1;
        wait_req("rst_run_request");
        pulse_done();
        wait_state(S_RUN, 20, "rst_reach_run");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_run_outputs", {29'd0, run, cfg_request, fault}, 32'd0);
        chk("rst_run_state", 32'(state), 32'(S_IDLE));
        step(1);
        reset_n = 1'b1;
        step(1);
        chk("rst_run_release", 32'(state), 32'(S_IDLE));

        // Async reset while in CONFIG
        wait_req("rst_cfg_request");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_cfg_outputs", {29'd0, run, cfg_request, fault}, 32'd0);
        chk("rst_cfg_state", 32'(state), 32'(S_IDLE));
        step(1);
        reset_n = 1'b1;
        step(1);
        chk("rst_cfg_release", 32'(state), 32'(S_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
